// File: rtl/dps_decoder_serial_pkg.sv
// Shared types and constants for the bit-serial Fibonacci-numeral decoder.
// Holds the FSM state encoding and the default codeword and data widths.
package dps_decoder_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fibonacci number F(n), with F(1) = F(2) = 1
  function automatic int fns_fib(input int n);
    int a;
    int b;
    int t;
    a = 1;
    b = 1;
    for (int i = 2; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (n <= 2) ? 1 : b;
  endfunction

  // The largest CW-bit codeword decodes to F(CW+2)-1
  function automatic int fns_dw_nominal(input int cw);
    return $clog2(fns_fib(cw + 2));
  endfunction

  localparam int CW_DEF   = 8;
  localparam int DW_DEF   = fns_dw_nominal(CW_DEF);
  localparam int CNTW_DEF = 4;

endpackage

// File: rtl/dps_decoder_serial_if.sv
// Bus link between the codeword source, the decoder and the data sink.
// The slave modport is the decoder's view of the bus.
interface dps_decoder_serial_if #(
  parameter int CW = 8,
  parameter int DW = 6
);

  logic [CW-1:0] code_in;
  logic          code_valid;
  logic          code_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready;
  logic          ovf;

  modport slave (
    input  code_in,
    input  code_valid,
    output code_ready,
    output data_out,
    output data_valid,
    input  data_ready,
    output ovf
  );

  modport master (
    output code_in,
    output code_valid,
    input  code_ready,
    input  data_out,
    input  data_valid,
    output data_ready,
    input  ovf
  );

endinterface

// File: rtl/dps_decoder_serial_weight_gen.sv
// Iterative Fibonacci weight generator: o_weight walks 1,1,2,3,5,... one step per i_step.
// The next-weight register sticks at all-ones instead of wrapping.
module dps_decoder_serial_weight_gen #(
  parameter int WW = 8
) (
  input  logic          i_clock,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_step,
  output logic [WW-1:0] o_weight
);

  logic [WW-1:0] r_wa;
  logic [WW-1:0] r_wb;
  logic [WW:0]   w_sum;
  logic [WW-1:0] w_wb_nxt;

  assign w_sum    = {1'b0, r_wa} + {1'b0, r_wb};
  assign w_wb_nxt = w_sum[WW] ? {WW{1'b1}} : w_sum[WW-1:0];
  assign o_weight = r_wa;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wa <= '0;
      r_wb <= '0;
    end else if (i_load) begin
      r_wa <= WW'(1);
      r_wb <= WW'(1);
    end else if (i_step) begin
      r_wa <= r_wb;
      r_wb <= w_wb_nxt;
    end
  end

endmodule

// File: rtl/dps_decoder_serial.sv
// Bit-serial FNS codeword decoder: sums Fibonacci-weighted codeword bits LSB first,
// one bit per cycle, and hands the result to the sink over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a codeword; accept latches it and clears the sum
// ST_RUN  | one codeword bit per cycle, CW cycles in total
// ST_DONE | result held on data_out until the sink takes it
module dps_decoder_serial
  import dps_decoder_serial_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int DW   = DW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_rst_n,
  dps_decoder_serial_if.slave  bus
);

  localparam int AW = DW + 2;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_shift;
  logic [CNTW-1:0] r_cnt;
  logic [AW-1:0]   r_acc;
  logic [AW-1:0]   w_weight;
  logic [AW:0]     w_sum;
  logic [AW-1:0]   w_acc_nxt;
  logic            w_code_ready;
  logic            w_data_valid;
  logic            w_accept;
  logic            w_run;
  logic            w_last;

  assign w_last = (r_cnt == CNTW'(CW - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_code_ready = 1'b0;
    w_data_valid = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_code_ready = 1'b1;
        if (bus.code_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_data_valid = 1'b1;
        if (bus.data_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = w_code_ready & bus.code_valid;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  dps_decoder_serial_weight_gen #(
    .WW (AW)
  ) u_weight_gen (
    .i_clock  (i_clock),
    .i_rst_n  (i_rst_n),
    .i_load   (w_accept),
    .i_step   (w_run),
    .o_weight (w_weight)
  );

  // Top accumulator bit is a sticky flag: set once any sum reaches 2^DW
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_weight};
  assign w_acc_nxt = {r_acc[AW-1] | (|w_sum[AW:DW]), w_sum[DW:0]};

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_shift <= bus.code_in;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_run) begin
      if (r_shift[0]) r_acc <= w_acc_nxt;
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + CNTW'(1);
    end
  end

  assign bus.code_ready = w_code_ready;
  assign bus.data_valid = w_data_valid;
  assign bus.data_out   = r_acc[DW-1:0];
  assign bus.ovf        = r_acc[AW-1];

endmodule

// File: tb/tb_dps_decoder_serial.sv
// Directed bench for dps_decoder_serial: a DW=6 instance for decoding, latency,
// backpressure and reset, and a DW=4 instance for overflow.
module tb_dps_decoder_serial;

  typedef struct {
    int data;
    bit ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb8[$];
  exp_t sb4[$];

  dps_decoder_serial_if #(.CW(8), .DW(6)) if8 ();
  dps_decoder_serial_if #(.CW(8), .DW(4)) if4 ();

  dps_decoder_serial #(.CW(8), .DW(6), .CNTW(4)) dut_a (
    .i_clock (clk),
    .i_rst_n (rst_n),
    .bus     (if8)
  );

  dps_decoder_serial #(.CW(8), .DW(4), .CNTW(4)) dut_b (
    .i_clock (clk),
    .i_rst_n (rst_n),
    .bus     (if4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t fns_model(input logic [7:0] code, input int dw);
    exp_t e;
    int a, b, t, s;
    a = 1; b = 1; s = 0;
    for (int k = 0; k < 8; k++) begin
      if (code[k]) s += a;
      t = a + b;
      a = b;
      b = t;
    end
    e.data = s % (1 << dw);
    e.ovf  = (s >= (1 << dw));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the DW=6 instance; hold = cycles of data_ready=0 in DONE
  task automatic send8(input logic [7:0] code, input int hold);
    int   lat;
    exp_t e;
    logic [5:0] held;
    chk("a_code_ready_idle", if8.code_ready, 1'b1);
    if8.code_in    = code;
    if8.code_valid = 1'b1;
    sb8.push_back(fns_model(code, 6));
    tick();
    if8.code_valid = 1'b0;
    chk("a_code_ready_run", if8.code_ready, 1'b0);
    lat = 0;
    while (!if8.data_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk($sformatf("a_latency_%02h", code), lat, 8);
    if (sb8.size() == 0) begin
      chk("a_sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb8.pop_front();
      chk($sformatf("a_data_%02h", code), if8.data_out, e.data);
      chk($sformatf("a_ovf_%02h", code), if8.ovf, e.ovf);
    end
    held = if8.data_out;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        if8.code_in    = 8'hFF;
        if8.code_valid = 1'b1;
      end
      tick();
      if8.code_valid = 1'b0;
      chk("a_bp_valid", if8.data_valid, 1'b1);
      chk("a_bp_data", if8.data_out, held);
      chk("a_bp_code_ready", if8.code_ready, 1'b0);
    end
    if8.data_ready = 1'b1;
    tick();
    if8.data_ready = 1'b0;
    chk("a_valid_drop", if8.data_valid, 1'b0);
    chk("a_back_idle", if8.code_ready, 1'b1);
  endtask

  task automatic send4(input logic [7:0] code);
    int   lat;
    exp_t e;
    if4.code_in    = code;
    if4.code_valid = 1'b1;
    sb4.push_back(fns_model(code, 4));
    tick();
    if4.code_valid = 1'b0;
    lat = 0;
    while (!if4.data_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk($sformatf("b_latency_%02h", code), lat, 8);
    if (sb4.size() == 0) begin
      chk("b_sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb4.pop_front();
      chk($sformatf("b_data_%02h", code), if4.data_out, e.data);
      chk($sformatf("b_ovf_%02h", code), if4.ovf, e.ovf);
    end
    if4.data_ready = 1'b1;
    tick();
    if4.data_ready = 1'b0;
    chk("b_back_idle", if4.code_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] walk;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    if8.code_in = '0; if8.code_valid = 1'b0; if8.data_ready = 1'b0;
    if4.code_in = '0; if4.code_valid = 1'b0; if4.data_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    chk("rst_code_ready", if8.code_ready, 1'b1);
    chk("rst_data_valid", if8.data_valid, 1'b0);
    chk("rst_data_out", if8.data_out, 6'd0);
    chk("rst_ovf", if8.ovf, 1'b0);
    chk("rst_b_code_ready", if4.code_ready, 1'b1);

    // Stray data_ready in IDLE must be ignored
    if8.data_ready = 1'b1;
    tick();
    if8.data_ready = 1'b0;
    chk("idle_ready_ignored", if8.code_ready, 1'b1);

    send8(8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      walk = 8'h01 << i;
      send8(walk, 0);
    end
    send8(8'hAA, 0);
    send8(8'hFF, 0);
    send8(8'h55, 0);

    // Backpressure, with an FF codeword offered during DONE that must be dropped
    send8(8'h01, 5);
    tick();
    chk("bp_no_capture", if8.code_ready, 1'b1);
    chk("bp_no_capture_valid", if8.data_valid, 1'b0);

    // Reset in RUN cycle 4 of an FF codeword
    if8.code_in    = 8'hFF;
    if8.code_valid = 1'b1;
    tick();
    if8.code_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_run_busy", if8.code_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_code_ready", if8.code_ready, 1'b1);
    chk("mid_rst_data_valid", if8.data_valid, 1'b0);
    chk("mid_rst_data_out", if8.data_out, 6'd0);
    chk("mid_rst_ovf", if8.ovf, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    send8(8'h03, 0);

    send4(8'hFF);
    send4(8'h01);

    chk("sb_a_drained", sb8.size(), 0);
    chk("sb_b_drained", sb4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
